// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue controller: tracks in-flight register writes and
// grants or stalls decoded instructions on RAW, WAW and capacity hazards.
module reg_scoreboard #(
    parameter int unsigned XCNT         = 32,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned STALL_W      = 32
) (
    input  logic                            CLK,
    input  logic                            RSTN,
    input  logic                            ISSUE_VALID,
    input  logic [$clog2(XCNT)-1:0]         ISSUE_RS1,
    input  logic [$clog2(XCNT)-1:0]         ISSUE_RS2,
    input  logic [$clog2(XCNT)-1:0]         ISSUE_RD,
    input  logic                            USES_RS1,
    input  logic                            USES_RS2,
    input  logic                            WRITES_RD,
    output logic                            ISSUE_READY,
    output logic                            DECODE_HAZARD,
    input  logic                            WB_VALID,
    input  logic [$clog2(XCNT)-1:0]         WB_RD,
    input  logic                            FLUSH,
    output logic [XCNT-1:0]                 PENDING,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] INFLIGHT,
    output logic [STALL_W-1:0]              STALL_CNT
);

    localparam int unsigned RW = $clog2(XCNT);
    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

    logic [XCNT-1:0]    pending_q, pending_d;
    logic [IW-1:0]      inflight_q, inflight_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic clr_hit;
    logic busy_rs1, busy_rs2, busy_rd;
    logic raw_haz, waw_haz, cap_haz;
    logic ready, fire, set;

    // Hazard detection with same-cycle writeback bypass (regfile is write-before-read)
    always_comb begin
        clr_hit  = WB_VALID && (WB_RD != '0) && pending_q[WB_RD];
        busy_rs1 = pending_q[ISSUE_RS1] && !(clr_hit && (WB_RD == ISSUE_RS1));
        busy_rs2 = pending_q[ISSUE_RS2] && !(clr_hit && (WB_RD == ISSUE_RS2));
        busy_rd  = pending_q[ISSUE_RD]  && !(clr_hit && (WB_RD == ISSUE_RD));
        raw_haz  = (USES_RS1 && (ISSUE_RS1 != '0) && busy_rs1)
                || (USES_RS2 && (ISSUE_RS2 != '0) && busy_rs2);
        waw_haz  = WRITES_RD && (ISSUE_RD != '0) && busy_rd;
        cap_haz  = WRITES_RD && (ISSUE_RD != '0)
                && ((inflight_q - IW'(clr_hit)) == IW'(MAX_INFLIGHT));
        ready    = !RSTN && !FLUSH && !raw_haz && !waw_haz && !cap_haz;
        fire     = ISSUE_VALID && ready;
        set      = fire && WRITES_RD && (ISSUE_RD != '0);
    end

    // Next-state: clear on retire, set on issue (set wins), flush wipes everything
    always_comb begin
        pending_d  = pending_q;
        inflight_d = inflight_q;
        stall_d    = stall_q;
        if (clr_hit) begin
            pending_d[WB_RD] = 1'b0;
        end
        if (set) begin
            pending_d[ISSUE_RD] = 1'b1;
        end
        pending_d[0] = 1'b0;
        inflight_d   = inflight_q + IW'(set) - IW'(clr_hit);
        if (FLUSH) begin
            pending_d  = '0;
            inflight_d = '0;
        end
        if (ISSUE_VALID && !ready && !FLUSH && !RSTN && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            pending_q  <= '0;
            inflight_q <= '0;
            stall_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
        end
    end

    assign ISSUE_READY   = ready;
    assign DECODE_HAZARD = ISSUE_VALID && !ready;
    assign PENDING       = pending_q;
    assign INFLIGHT      = inflight_q;
    assign STALL_CNT     = stall_q;

    logic unused_rw;
    assign unused_rw = ^RW;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: hazards, bypass, capacity,
// stray writebacks, flush and mid-operation reset.
module tb_reg_scoreboard;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RS1, ISSUE_RS2, ISSUE_RD;
    logic        USES_RS1, USES_RS2, WRITES_RD;
    logic        ISSUE_READY, DECODE_HAZARD;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic        FLUSH;
    logic [31:0] PENDING;
    logic [2:0]  INFLIGHT;
    logic [31:0] STALL_CNT;

    int checks   = 0;
    int failures = 0;

    reg_scoreboard #(.XCNT(32), .MAX_INFLIGHT(4), .STALL_W(32)) dut (
        .CLK(CLK), .RSTN(RSTN), .ISSUE_VALID(ISSUE_VALID),
        .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2), .ISSUE_RD(ISSUE_RD),
        .USES_RS1(USES_RS1), .USES_RS2(USES_RS2), .WRITES_RD(WRITES_RD),
        .ISSUE_READY(ISSUE_READY), .DECODE_HAZARD(DECODE_HAZARD),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD), .FLUSH(FLUSH),
        .PENDING(PENDING), .INFLIGHT(INFLIGHT), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ISSUE_VALID = 1'b0; ISSUE_RS1 = '0; ISSUE_RS2 = '0; ISSUE_RD = '0;
        USES_RS1 = 1'b0; USES_RS2 = 1'b0; WRITES_RD = 1'b0;
        WB_VALID = 1'b0; WB_RD = '0; FLUSH = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2, input logic u2);
        ISSUE_VALID = 1'b1; ISSUE_RD = rd; WRITES_RD = wr;
        ISSUE_RS1 = rs1; USES_RS1 = u1; ISSUE_RS2 = rs2; USES_RS2 = u2;
    endtask

    task automatic wb(input logic [4:0] rd);
        WB_VALID = 1'b1; WB_RD = rd;
    endtask

    task automatic state(input string tag, input logic [31:0] pend, input logic [2:0] infl,
                         input logic [31:0] stall);
        check({tag, "_pending"}, PENDING, pend);
        check({tag, "_inflight"}, 32'(INFLIGHT), 32'(infl));
        check({tag, "_stall"}, STALL_CNT, stall);
    endtask

    initial begin
        idle();
        RSTN = 1'b1;
        #1;
        // Reset: never ready, hazard mirrors valid
        ISSUE_VALID = 1'b1;
        #1;
        check("rst_ready", 32'(ISSUE_READY), 32'd0);
        check("rst_hazard", 32'(DECODE_HAZARD), 32'd1);
        step(); step();
        state("rst", 32'h0, 3'd0, 32'd0);
        RSTN = 1'b0;
        idle();

        // ADD x5,x1,x2
        issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1); #1;
        check("add_ready", 32'(ISSUE_READY), 32'd1);
        step(); idle();
        state("add", 32'h0000_0020, 3'd1, 32'd0);

        // SUB x6,x5,x3 stalls on RAW for two cycles
        issue(5'd6, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1); #1;
        check("sub_hazard", 32'(DECODE_HAZARD), 32'd1);
        check("sub_ready", 32'(ISSUE_READY), 32'd0);
        step();
        check("sub_stall1", STALL_CNT, 32'd1);
        step();
        check("sub_stall2", STALL_CNT, 32'd2);
        // Writeback of x5 bypasses into the same cycle
        wb(5'd5); #1;
        check("sub_bypass_ready", 32'(ISSUE_READY), 32'd1);
        step(); idle();
        state("sub", 32'h0000_0040, 3'd1, 32'd2);

        // WAW on x7 with same-register set/clear
        issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("x7_ready", 32'(ISSUE_READY), 32'd1);
        step();
        state("x7", 32'h0000_00C0, 3'd2, 32'd2);
        #1;
        check("waw_hazard", 32'(DECODE_HAZARD), 32'd1);
        step();
        check("waw_stall", STALL_CNT, 32'd3);
        wb(5'd7); #1;
        check("waw_bypass_ready", 32'(ISSUE_READY), 32'd1);
        step(); idle();
        state("waw", 32'h0000_00C0, 3'd2, 32'd3);
        wb(5'd6); step();
        wb(5'd7); step(); idle();
        state("drain", 32'h0, 3'd0, 32'd3);

        // Capacity: x1..x4 back to back
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            step();
        end
        idle();
        state("cap_fill", 32'h0000_001E, 3'd4, 32'd3);
        issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("cap_x9_ready", 32'(ISSUE_READY), 32'd0);
        step();
        check("cap_stall", STALL_CNT, 32'd4);
        // Store-type: sources free, no destination
        issue(5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1); #1;
        check("store_ready", 32'(ISSUE_READY), 32'd1);
        step();
        state("store", 32'h0000_001E, 3'd4, 32'd4);
        issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); wb(5'd2); #1;
        check("cap_wb_ready", 32'(ISSUE_READY), 32'd1);
        step(); idle();
        state("cap_admit", 32'h0000_021A, 3'd4, 32'd4);

        // x0 destination and stray writebacks change nothing
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1); #1;
        check("x0_ready", 32'(ISSUE_READY), 32'd1);
        step(); idle();
        state("x0_issue", 32'h0000_021A, 3'd4, 32'd4);
        wb(5'd0); step(); idle();
        state("wb_x0", 32'h0000_021A, 3'd4, 32'd4);
        wb(5'd20); step(); idle();
        state("wb_stray", 32'h0000_021A, 3'd4, 32'd4);

        // Flush with three pending, concurrent writeback and issue
        wb(5'd1); step(); idle();
        state("pre_flush", 32'h0000_0218, 3'd3, 32'd4);
        FLUSH = 1'b1; wb(5'd3); issue(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check("flush_ready", 32'(ISSUE_READY), 32'd0);
        step(); idle();
        state("flush", 32'h0, 3'd0, 32'd4);

        // Reset mid-stall, then a stale writeback
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
        issue(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); step();
        state("pre_rst", 32'h0000_0020, 3'd1, 32'd5);
        RSTN = 1'b1; step();
        state("mid_rst", 32'h0, 3'd0, 32'd0);
        check("mid_rst_ready", 32'(ISSUE_READY), 32'd0);
        check("mid_rst_hazard", 32'(DECODE_HAZARD), 32'd1);
        RSTN = 1'b0; #1;
        check("post_rst_ready", 32'(ISSUE_READY), 32'd1);
        idle(); wb(5'd5); step(); idle();
        state("stale_wb", 32'h0, 3'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
